mips_prog_loader: RTL and testbench

//  Byte-stream program loader for MIPS_32_BITS: the writer side of the CPU's word memory.

---
 rtl/mips_prog_loader.sv | 157 +++++++++++++++
 tb/tb_mips_prog_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_prog_loader.sv
// ============================================================================
//  Module      : mips_prog_loader
//  Description : Byte-stream program loader for the MIPS_32_BITS word memory.
//                Receives a framed, MSB-first byte stream
//                  ADDR(4) | COUNT(4) | COUNT x DATA(4) | CHK(1)
//                assembles big-endian 32-bit words and writes them to
//                consecutive (wrapping) word addresses. It keeps the CPU
//                halted while a frame is in progress and checks a trailing
//                XOR checksum over all data bytes.
//  Ports       : clk1 / rst        clock, synchronous active-high reset
//                in_valid/in_data  byte stream input
//                in_ready          byte accepted when in_valid & in_ready
//                mem_we/mem_addr/mem_wdata  registered word write port
//                cpu_halt          high while a frame is in progress
//                load_done         one-cycle end-of-frame pulse
//                load_err          sticky checksum mismatch flag
//                busy              frame partially received
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mips_prog_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_halt,
    output logic              load_done,
    output logic              load_err,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_ADDR = 3'd0,
        S_CNT  = 3'd1,
        S_DATA = 3'd2,
        S_CHK  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_bcnt;
    logic [23:0]       r_shift;
    logic [ADDR_W-1:0] r_waddr;
    logic [ADDR_W:0]   r_wleft;
    logic [7:0]        r_xor;
    logic              r_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              r_halt;
    logic              r_err;

    logic              w_accept;
    logic              w_word_end;
    logic [31:0]       w_word;
    logic [ADDR_W:0]   w_cnt;

    // in_ready depends on the state register only, so there is no
    // combinational path from in_valid back to in_ready.
    assign in_ready   = (r_state != S_DONE);
    assign load_done  = (r_state == S_DONE);
    assign busy       = (r_state != S_ADDR) || (r_bcnt != 2'd0);
    assign w_accept   = in_valid && (r_state != S_DONE);
    assign w_word_end = w_accept && (r_bcnt == 2'd3);
    assign w_word     = {r_shift, in_data};
    assign w_cnt      = w_word[ADDR_W:0];

    assign mem_we     = r_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign cpu_halt   = r_halt;
    assign load_err   = r_err;

    always_ff @(posedge clk1) begin
        if (rst) begin
            r_state <= S_ADDR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_ADDR: if (w_word_end) w_state_nxt = S_CNT;
            S_CNT:  if (w_word_end) w_state_nxt = (w_cnt == '0) ? S_CHK : S_DATA;
            S_DATA: if (w_word_end && (r_wleft == {{ADDR_W{1'b0}}, 1'b1})) w_state_nxt = S_CHK;
            S_CHK:  if (w_accept) w_state_nxt = S_DONE;
            S_DONE: w_state_nxt = S_ADDR;
            default: w_state_nxt = S_ADDR;
        endcase
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            r_bcnt      <= 2'd0;
            r_shift     <= 24'd0;
            r_waddr     <= '0;
            r_wleft     <= '0;
            r_xor       <= 8'd0;
            r_we        <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'd0;
            r_halt      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (w_accept) begin
                if (r_state != S_CHK) begin
                    r_shift <= w_word[23:0];
                    r_bcnt  <= r_bcnt + 2'd1;
                end
                case (r_state)
                    S_ADDR: begin
                        // First byte of a new frame: halt the CPU and
                        // clear the previous frame's result.
                        if (r_bcnt == 2'd0) begin
                            r_halt <= 1'b1;
                            r_err  <= 1'b0;
                            r_xor  <= 8'd0;
                        end
                        if (w_word_end) r_waddr <= w_word[ADDR_W-1:0];
                    end
                    S_CNT: begin
                        if (w_word_end) r_wleft <= w_cnt;
                    end
                    S_DATA: begin
                        r_xor <= r_xor ^ in_data;
                        if (w_word_end) begin
                            r_we        <= 1'b1;
                            r_mem_addr  <= r_waddr;
                            r_mem_wdata <= w_word;
                            r_waddr     <= r_waddr + 1'b1;
                            r_wleft     <= r_wleft - 1'b1;
                        end
                    end
                    S_CHK: begin
                        r_err  <= (in_data != r_xor);
                        r_halt <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mips_prog_loader.sv
// ============================================================================
//  Module      : tb_mips_prog_loader
//  Description : Self-checking bench for mips_prog_loader. Directed frames
//                plus randomized frames; expected writes, checksum result
//                and flag timing come from a frame-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mips_prog_loader;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk1 = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_halt;
    logic              load_done;
    logic              load_err;
    logic              busy;

    mips_prog_loader #(.ADDR_W(ADDR_W)) dut (
        .clk1      (clk1),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_halt  (cpu_halt),
        .load_done (load_done),
        .load_err  (load_err),
        .busy      (busy)
    );

    always #5 clk1 = ~clk1;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int done_cnt = 0;
    int rdy_low_cnt = 0;
    int frames = 0;
    logic [31:0] fw[$];

    // Event counters sampled mid-cycle.
    always @(negedge clk1) begin
        if (mem_we === 1'b1)    we_cnt++;
        if (load_done === 1'b1) done_cnt++;
        if (in_ready !== 1'b1)  rdy_low_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    // Offer one byte after a random gap; return one step after it is accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int  g;
        int  tries;
        logic rdy;
        g = (gap > 0) ? int'($urandom_range(gap, 0)) : 0;
        in_valid = 1'b0;
        repeat (g) tick();
        in_valid = 1'b1;
        in_data  = b;
        tries    = 0;
        forever begin
            @(negedge clk1);
            rdy = in_ready;
            tick();
            if (rdy === 1'b1) break;
            tries++;
            if (tries > 8) begin
                check("accept_timeout", {31'd0, rdy}, 32'd1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    function automatic logic [7:0] data_xor();
        logic [7:0] x = 8'h00;
        foreach (fw[i]) x = x ^ fw[i][31:24] ^ fw[i][23:16] ^ fw[i][15:8] ^ fw[i][7:0];
        return x;
    endfunction

    // Send one frame using words from fw and check it against the model.
    task automatic send_frame(input logic [31:0] aw, input logic [31:0] cw,
                              input logic [7:0] chk, input int gap);
        int   n;
        int   we0;
        int   ea;
        logic exp_err;
        n       = int'(cw[ADDR_W:0]);
        exp_err = (chk != data_xor());
        we0     = we_cnt;
        ea      = 0;
        for (int k = 0; k < 4; k++) begin
            send_byte(aw[31-8*k -: 8], gap);
            if (k == 0) begin
                check("halt_set", {31'd0, cpu_halt}, 32'd1);
                check("err_clr",  {31'd0, load_err}, 32'd0);
            end
        end
        for (int k = 0; k < 4; k++) send_byte(cw[31-8*k -: 8], gap);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 4; k++) begin
                send_byte(fw[i][31-8*k -: 8], gap);
                if (k == 3) begin
                    ea = (int'(aw % DEPTH) + i) % DEPTH;
                    check("we_pulse", {31'd0, mem_we}, 32'd1);
                    check("we_addr",  {22'd0, mem_addr}, ea);
                    check("we_data",  mem_wdata, fw[i]);
                end
            end
        end
        send_byte(chk, gap);
        check("done_pulse", {31'd0, load_done}, 32'd1);
        check("rdy_done",   {31'd0, in_ready},  32'd0);
        check("err_done",   {31'd0, load_err},  {31'd0, exp_err});
        check("halt_done",  {31'd0, cpu_halt},  32'd0);
        tick();
        check("done_end",   {31'd0, load_done}, 32'd0);
        check("rdy_after",  {31'd0, in_ready},  32'd1);
        check("err_sticky", {31'd0, load_err},  {31'd0, exp_err});
        check("busy_after", {31'd0, busy},      32'd0);
        check("we_total",   we_cnt - we0,       n);
        if (n > 0) check("addr_hold", {22'd0, mem_addr}, ea);
        frames++;
    endtask

    initial begin
        int n;
        logic [31:0] aw;
        logic [31:0] cw;
        logic [7:0]  chk;
        int we0;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) tick();
        check("rst_rdy",   {31'd0, in_ready},  32'd1);
        check("rst_we",    {31'd0, mem_we},    32'd0);
        check("rst_addr",  {22'd0, mem_addr},  32'd0);
        check("rst_wdata", mem_wdata,          32'd0);
        check("rst_halt",  {31'd0, cpu_halt},  32'd0);
        check("rst_done",  {31'd0, load_done}, 32'd0);
        check("rst_err",   {31'd0, load_err},  32'd0);
        check("rst_busy",  {31'd0, busy},      32'd0);
        rst = 1'b0;
        tick();

        // Test 1: good two-word frame at address 0.
        fw = '{32'h280000C8, 32'h200100C8};
        send_frame(32'h0, 32'd2, 8'h09, 0);

        // Test 2: same frame, bad checksum; error stays until next frame.
        send_frame(32'h0, 32'd2, 8'h0A, 0);
        repeat (3) tick();
        check("err_hold", {31'd0, load_err}, 32'd1);

        // Test 3: address wrap.
        fw = '{32'h00000001, 32'h00000002};
        send_frame(32'h000003FF, 32'd2, 8'h03, 0);

        // Test 4: empty frame.
        fw = {};
        send_frame(32'h00000010, 32'd0, 8'h00, 0);
        check("halt_idle", {31'd0, cpu_halt}, 32'd0);

        // Test 5: reset after two data bytes of word 0.
        we0 = we_cnt;
        for (int k = 0; k < 4; k++) send_byte(8'h00, 0);
        for (int k = 0; k < 4; k++) send_byte((k == 3) ? 8'h02 : 8'h00, 0);
        send_byte(8'h28, 0);
        send_byte(8'h00, 0);
        check("mid_halt", {31'd0, cpu_halt}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_we",   {31'd0, mem_we},   32'd0);
        check("mr_halt", {31'd0, cpu_halt}, 32'd0);
        check("mr_busy", {31'd0, busy},     32'd0);
        check("mr_rdy",  {31'd0, in_ready}, 32'd1);
        repeat (3) tick();
        check("mr_nowrite", we_cnt - we0, 0);
        fw = '{32'h280000C8, 32'h200100C8};
        send_frame(32'h0, 32'd2, 8'h09, 0);

        // Test 6: random gaps on the test-1 frame.
        send_frame(32'h0, 32'd2, 8'h09, 5);

        // Randomized frames: junk in upper ADDR/COUNT bits, random data,
        // occasionally corrupted checksum.
        for (int f = 0; f < 10; f++) begin
            n  = int'($urandom_range(4, 0));
            aw = $urandom;
            if (f % 3 == 0) aw = (aw & ~32'h3FF) | 32'h3FE;
            cw = ($urandom & ~32'h7FF) | n;
            fw = {};
            for (int i = 0; i < n; i++) fw.push_back($urandom);
            chk = data_xor();
            if ($urandom_range(3, 0) == 0) chk = chk ^ 8'(1 << $urandom_range(7, 0));
            send_frame(aw, cw, chk, int'($urandom_range(3, 0)));
        end

        tick();
        check("done_count",    done_cnt,    frames);
        check("rdy_low_count", rdy_low_cnt, frames);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
